// File: rtl/des_pkg.sv
// Shared DES definitions: engine state encoding, P/IP/FP index tables and the
// matching permutation functions (DES numbering, bit 1 = MSB).
package des_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  localparam int IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_TAB [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  // Output bit i (DES numbering) takes input bit TAB[i]; vector index = width - DES bit.
  function automatic logic [31:0] des_p(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_TAB[i])];
    return y;
  endfunction

  function automatic logic [63:0] des_ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_TAB[i])];
    return y;
  endfunction

  function automatic logic [63:0] des_fp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_TAB[i])];
    return y;
  endfunction

endpackage

// File: rtl/des_pbox.sv
// Pure combinational DES P permutation of the packed {S1..S8} S-box word.
module des_pbox
  import des_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  assign dout = des_p(din);

endmodule

// File: rtl/des_feistel_round_engine.sv
// Iterative DES Feistel round engine fed by an external E/key/S-box path.
// Define DES_IP_FP_EN to apply IP at load and FP on the result block.
module des_feistel_round_engine
  import des_pkg::*;
#(
  parameter int NROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_block,
  output logic [31:0] r_half,
  output logic [3:0]  round_idx,
  output logic        f_req,
  input  logic        f_valid,
  input  logic [31:0] sbox_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_block
);

  state_t      state_q, state_d;
  logic [31:0] l_q, r_q;
  logic [3:0]  round_q;
  logic [63:0] out_q;
  logic [31:0] p_out;
  logic [63:0] load_blk;
  logic [63:0] fin_blk;
  logic        last_round;

  des_pbox u_pbox (
    .din  (sbox_out),
    .dout (p_out)
  );

  assign last_round = (round_q == 4'(NROUNDS - 1));

  // Final round result is {R16,L16}: R16 = L15 ^ P(S), L16 = R15.
`ifdef DES_IP_FP_EN
  assign load_blk = des_ip(in_block);
  assign fin_blk  = des_fp({l_q ^ p_out, r_q});
`else
  assign load_blk = in_block;
  assign fin_blk  = {l_q ^ p_out, r_q};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = ROUND;
      ROUND:   if (f_valid && last_round) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    f_req     = (state_q == ROUND);
    out_valid = (state_q == DONE);
  end

  // Halves and round index only move on a load or an accepted f_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_q     <= '0;
      r_q     <= '0;
      round_q <= '0;
      out_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            l_q     <= load_blk[63:32];
            r_q     <= load_blk[31:0];
            round_q <= '0;
          end
        end
        ROUND: begin
          if (f_valid) begin
            l_q <= r_q;
            r_q <= l_q ^ p_out;
            if (last_round) out_q   <= fin_blk;
            else            round_q <= round_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign r_half    = r_q;
  assign round_idx = round_q;
  assign out_block = out_q;

endmodule

// File: tb/tb_des_feistel_round_engine.sv
// Randomized bench for des_feistel_round_engine with a full DES reference
// (key schedule, E, S-boxes, P, IP) acting as upstream path and output model.
module tb_des_feistel_round_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, f_req, f_valid, out_valid, out_ready;
  logic [63:0] in_block, out_block;
  logic [31:0] r_half, sbox_out;
  logic [3:0]  round_idx;

  logic        in_valid1, in_ready1, f_req1, f_valid1, out_valid1, out_ready1;
  logic [63:0] in_block1, out_block1;
  logic [31:0] r_half1, sbox_out1;
  logic [3:0]  round_idx1;

  int checks = 0;
  int errors = 0;

  des_feistel_round_engine #(.NROUNDS(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .r_half(r_half), .round_idx(round_idx),
    .f_req(f_req), .f_valid(f_valid), .sbox_out(sbox_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block)
  );

  des_feistel_round_engine #(.NROUNDS(1)) u_p1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_block(in_block1), .r_half(r_half1), .round_idx(round_idx1),
    .f_req(f_req1), .f_valid(f_valid1), .sbox_out(sbox_out1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_block(out_block1)
  );

  int P_T [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                   2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  int IP_T [64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,
                    62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                    57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                    61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  int PC1_T [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,
                     10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                     63,55,47,39,31,23,15,7,62,54,46,38,30,22,
                     14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  int PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,
                     26,8,16,7,27,20,13,2,41,52,31,37,47,55,30,40,
                     51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int SH_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int SB [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11
  };

  logic [47:0] cur_ks [16];

  typedef struct packed {
    logic [16:0][31:0] r;
    logic [63:0]       out;
  } mres_t;

  function automatic logic [31:0] bp(input logic [31:0] x);
    logic [31:0] y = '0;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[i])];
    return y;
  endfunction

  function automatic logic [63:0] bip(input logic [63:0] x);
    logic [63:0] y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
    return y;
  endfunction

  // FP built as the inverse of IP rather than from its own table.
  function automatic logic [63:0] bfp(input logic [63:0] x);
    logic [63:0] y = '0;
    for (int i = 0; i < 64; i++) y[6'(64 - IP_T[i])] = x[6'(63 - i)];
    return y;
  endfunction

  // E: each 6-bit group j covers DES bits 4j..4j+5 with wrap-around.
  function automatic logic [47:0] be(input logic [31:0] r);
    logic [47:0] e = '0;
    for (int i = 0; i < 48; i++) e[6'(47 - i)] = r[5'(31 - ((4 * (i / 6) + (i % 6) + 31) % 32))];
    return e;
  endfunction

  function automatic logic [31:0] bs(input logic [47:0] x);
    logic [31:0] y = '0;
    logic [5:0]  six;
    int          v;
    for (int s = 0; s < 8; s++) begin
      six = x[47 - 6 * s -: 6];
      v = SB[s * 64 + int'({six[5], six[0]}) * 16 + int'(six[4:1])];
      y[31 - 4 * s -: 4] = 4'(v);
    end
    return y;
  endfunction

  task automatic set_key(input logic [63:0] key);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] k;
    cd = '0;
    for (int i = 0; i < 56; i++) cd[6'(55 - i)] = key[6'(64 - PC1_T[i])];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int t = 0; t < SH_T[r]; t++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      k = '0;
      for (int i = 0; i < 48; i++) k[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
      cur_ks[r] = k;
    end
  endtask

  function automatic mres_t des_model(input logic [63:0] lr0);
    mres_t       m;
    logic [31:0] l, r, t;
    l = lr0[63:32];
    r = lr0[31:0];
    m.r[0] = r;
    for (int i = 0; i < 16; i++) begin
      t = l ^ bp(bs(be(r) ^ cur_ks[i]));
      l = r;
      r = t;
      m.r[i + 1] = r;
    end
`ifdef DES_IP_FP_EN
    m.out = bfp({r, l});
`else
    m.out = {r, l};
`endif
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Transaction-level model of the main engine: 0 idle, 1 rounds, 2 result held.
  int    m_state = 0;
  int    m_k = 0;
  mres_t m_res;
  bit    mon_en = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= 0;
      m_k     <= 0;
    end else begin
      case (m_state)
        0: if (in_valid) begin
`ifdef DES_IP_FP_EN
             m_res <= des_model(bip(in_block));
`else
             m_res <= des_model(in_block);
`endif
             m_k     <= 0;
             m_state <= 1;
           end
        1: if (f_valid) begin
             if (m_k == 15) m_state <= 2;
             else           m_k <= m_k + 1;
           end
        default: if (out_ready) m_state <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst && mon_en) begin
      chk("in_ready", 64'(in_ready), 64'(m_state == 0));
      chk("f_req", 64'(f_req), 64'(m_state == 1));
      chk("out_valid", 64'(out_valid), 64'(m_state == 2));
      if (m_state == 1) begin
        chk("round_idx", 64'(round_idx), 64'(m_k));
        chk("r_half", 64'(r_half), 64'(m_res.r[m_k]));
      end
      if (m_state == 2) chk("out_block", out_block, m_res.out);
    end
  end

  task automatic run_block(input logic [63:0] key, input logic [63:0] blk, input int maxgap,
                           input int bp_cycles, input bit pulse,
                           output logic [63:0] res, output int lat);
    int gap, n, bpc;
    bit done;
    set_key(key);
    bpc = bp_cycles;
    res = '0;
    lat = 0;
    @(negedge clk);
    out_ready = 1'($urandom_range(1, 0));
    f_valid = 1'($urandom_range(1, 0));
    sbox_out = $urandom;
    @(negedge clk);
    out_ready = 1'b0;
    f_valid = 1'b0;
    in_block = blk;
    in_valid = 1'b1;
    gap = $urandom_range(maxgap, 0);
    n = 0;
    done = 1'b0;
    while (!done && n < 600) begin
      @(negedge clk);
      n++;
      in_valid = 1'b0;
      f_valid = 1'b0;
      if (out_valid) begin
        if (lat == 0) lat = n + 1;
        if (bpc > 0) begin
          bpc--;
          out_ready = 1'b0;
          in_valid = pulse ? 1'($urandom_range(1, 0)) : 1'b0;
          in_block = {$urandom, $urandom};
          f_valid = 1'($urandom_range(1, 0));
        end else begin
          res = out_block;
          out_ready = 1'b1;
          done = 1'b1;
        end
      end else if (f_req) begin
        if (gap > 0) gap--;
        else begin
          f_valid = 1'b1;
          sbox_out = bs(be(r_half) ^ cur_ks[round_idx]);
          gap = $urandom_range(maxgap, 0);
        end
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    f_valid = 1'b0;
    if (!done) chk("block_timeout", 64'(n), 64'(0));
  endtask

  task automatic p1_run(input logic [31:0] s, output logic [63:0] res);
    int n;
    res = '0;
    @(negedge clk);
    in_block1 = '0;
    in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    n = 0;
    while (!f_req1 && n < 10) begin @(negedge clk); n++; end
    f_valid1 = 1'b1;
    sbox_out1 = s;
    @(negedge clk);
    f_valid1 = 1'b0;
    n = 0;
    while (!out_valid1 && n < 10) begin @(negedge clk); n++; end
    chk("p1_out_valid", 64'(out_valid1), 64'(1));
    res = out_block1;
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [63:0] key_v, pt_v, vec_in, exp_vec, res, exp1, exp2, tmp;
  int          lat;
  bit          reached;
  mres_t       pin;

  initial begin
    in_valid = 0; in_block = '0; f_valid = 0; sbox_out = '0; out_ready = 0;
    in_valid1 = 0; in_block1 = '0; f_valid1 = 0; sbox_out1 = '0; out_ready1 = 0;
    key_v = 64'h133457799BBCDFF1;
    pt_v  = 64'h0123456789ABCDEF;
`ifdef DES_IP_FP_EN
    exp_vec = 64'h85E813540F0AB405;
    vec_in  = pt_v;
`else
    exp_vec = 64'h0A4CD99543423234;
    vec_in  = bip(pt_v);
`endif

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_f_req", 64'(f_req), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_block", out_block, 64'h0);
    chk("rst_r_half", 64'(r_half), 64'h0);
    chk("rst_round_idx", 64'(round_idx), 64'h0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Pin the reference model to the textbook vector.
    set_key(key_v);
    pin = des_model(bip(pt_v));
    chk("model_r16", 64'(pin.r[16]), 64'h0A4CD995);
    tmp = {pin.r[16], pin.r[15]};
    chk("model_pre", tmp, 64'h0A4CD99543423234);
    chk("model_fp", bfp(64'h0A4CD99543423234), 64'h85E813540F0AB405);

    // Single-round P placement.
`ifdef DES_IP_FP_EN
    exp1 = bfp(64'h0000080000000000);
    exp2 = bfp(64'h0080000000000000);
`else
    exp1 = 64'h0000080000000000;
    exp2 = 64'h0080000000000000;
`endif
    p1_run(32'h00000001, res);
    chk("p1_sbox_lsb", res, exp1);
    p1_run(32'h80000000, res);
    chk("p1_sbox_msb", res, exp2);

    run_block(key_v, vec_in, 0, 0, 1'b0, res, lat);
    chk("vector_nostall", res, exp_vec);
    chk("latency_cycles", 64'(lat), 64'(18));

    run_block(key_v, vec_in, 5, 0, 1'b0, res, lat);
    chk("vector_stall", res, exp_vec);

    // Abort in round 7.
    set_key(key_v);
    reached = 1'b0;
    @(negedge clk);
    in_block = vec_in;
    in_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
      f_valid = 1'b0;
      if (f_req && round_idx == 4'd7) begin
        reached = 1'b1;
        break;
      end
      if (f_req) begin
        f_valid = 1'b1;
        sbox_out = bs(be(r_half) ^ cur_ks[round_idx]);
      end
    end
    chk("reach_round7", 64'(reached), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'(1));
    chk("abort_f_req", 64'(f_req), 64'(0));
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_out_block", out_block, 64'h0);
    chk("abort_r_half", 64'(r_half), 64'h0);
    chk("abort_round_idx", 64'(round_idx), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("release_in_ready", 64'(in_ready), 64'(1));

    run_block(key_v, vec_in, 2, 10, 1'b1, res, lat);
    chk("vector_backpressure", res, exp_vec);
    @(negedge clk);
    chk("bp_single_block_idle", 64'(in_ready), 64'(1));
    chk("bp_single_block_no_req", 64'(f_req), 64'(0));

    for (int b = 0; b < 24; b++) begin
      run_block({$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(3, 0),
                $urandom_range(3, 0), 1'($urandom_range(1, 0)), res, lat);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
